// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: shadow scoreboard of ID/EX, EX/MEM, MEM/WB destinations driving stall, bubble and flush.
// Define PIPE_NO_FWD_EN for cores without a forwarding unit (any in-flight producer in ID/EX or EX/MEM stalls).
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              mem_br_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } shadow_t;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_FLUSH,
        ACT_FREEZE
    } action_t;

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    shadow_t          s1_q, s2_q, s3_q;
    shadow_t          s1_d, s2_d, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    action_t          action;

    logic rn_live, rm_live;
    logic s1_hit;
    logic hazard;

    function automatic logic writes_reg(input shadow_t s, input logic [REG_AW-1:0] r);
        return s.v & s.rw & (s.rd == r);
    endfunction

    // XZR reads never depend on an older instruction, so a zero-register source is simply not live.
    assign rn_live = id_valid & id_use_rn & (id_rn != ZERO_IDX);
    assign rm_live = id_valid & id_use_rm & (id_rm != ZERO_IDX);

    assign s1_hit = (rn_live & writes_reg(s1_q, id_rn)) | (rm_live & writes_reg(s1_q, id_rm));

`ifdef PIPE_NO_FWD_EN
    logic s2_hit;
    assign s2_hit = (rn_live & writes_reg(s2_q, id_rn)) | (rm_live & writes_reg(s2_q, id_rm));
    assign hazard = s1_hit | s2_hit;
`else
    assign hazard = s1_q.mr & s1_hit;
`endif

    // MEM/WB never hazards (write-through register file); it is tracked only to keep the scoreboard complete.
    logic unused_shadow;
    assign unused_shadow = ^{s2_q, s3_q};

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        action      = ACT_ADVANCE;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        s1_d        = '{v: id_valid, rd: id_rd, rw: id_regwrite, mr: id_memread};
        s2_d        = s1_q;
        s3_d        = s2_q;
        cnt_d       = cnt_q;

        if (mem_busy) begin
            action = ACT_FREEZE;
        end else if (mem_br_taken) begin
            action = ACT_FLUSH;
        end else if (hazard) begin
            action = ACT_STALL;
        end

        unique case (action)
            ACT_FREEZE: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                s1_d       = s1_q;
                s2_d       = s2_q;
                s3_d       = s2_q ^ s2_q ^ s3_q;
            end
            ACT_FLUSH: begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
                s1_d        = s1_q;
                s1_d.v      = 1'b0;
                s2_d.v      = 1'b0;
            end
            ACT_STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                s1_d        = s1_q;
                s1_d.v      = 1'b0;
                cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    assign stall_cnt = cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard/flush/freeze/saturation steps, then random traffic vs. an instruction-level model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 31;
    localparam int CNT_W    = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rn = '0;
    logic [REG_AW-1:0] id_rm = '0;
    logic              id_use_rn = 1'b0;
    logic              id_use_rm = 1'b0;
    logic [REG_AW-1:0] id_rd = '0;
    logic              id_regwrite = 1'b0;
    logic              id_memread = 1'b0;
    logic              mem_br_taken = 1'b0;
    logic              mem_busy = 1'b0;
    logic              pc_write, ifid_write, idex_bubble;
    logic              flush_ifid, flush_idex, flush_exmem;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .mem_br_taken(mem_br_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the instructions ahead of ID, indexed by how many stages ahead they are (0 = ID/EX).
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    instr_t older[3];
    int     model_cnt;
    int     vectors = 0;
    int     miscompares = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic instr_t empty_slot();
        instr_t e;
        e.v = 0; e.rd = 0; e.rw = 0; e.mr = 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) older[k] = empty_slot();
        model_cnt = 0;
    endtask

    // Does the ID-stage read of src depend on the result of instruction p?
    function automatic bit depends(input instr_t p, input int src, input bit used, input bit valid);
        return valid && used && p.v && p.rw && (p.rd == src) && (src != ZERO_REG);
    endfunction

    function automatic bit model_hazard();
        bit dep[2];
        for (int k = 0; k < 2; k++)
            dep[k] = depends(older[k], int'(id_rn), id_use_rn, id_valid) ||
                     depends(older[k], int'(id_rm), id_use_rm, id_valid);
`ifdef PIPE_NO_FWD_EN
        return dep[0] || dep[1];
`else
        return older[0].mr && dep[0];
`endif
    endfunction

    // Called at a falling edge with inputs already driven: check outputs, then advance the model on the rising edge.
    task automatic tick(input string tag);
        bit hz, e_pc, e_ifid, e_bub, e_fl;
        instr_t incoming;
        #1;
        hz = model_hazard();
        if (mem_busy)          begin e_pc = 0; e_ifid = 0; e_bub = 0; e_fl = 0; end
        else if (mem_br_taken) begin e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 1; end
        else if (hz)           begin e_pc = 0; e_ifid = 0; e_bub = 1; e_fl = 0; end
        else                   begin e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0; end
        check({tag, ".pc_write"},    32'(pc_write),    32'(e_pc));
        check({tag, ".ifid_write"},  32'(ifid_write),  32'(e_ifid));
        check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
        check({tag, ".flush_ifid"},  32'(flush_ifid),  32'(e_fl));
        check({tag, ".flush_idex"},  32'(flush_idex),  32'(e_fl));
        check({tag, ".flush_exmem"}, 32'(flush_exmem), 32'(e_fl));
        check({tag, ".stall_cnt"},   32'(stall_cnt),   32'(model_cnt));
        incoming.v = id_valid; incoming.rd = int'(id_rd); incoming.rw = id_regwrite; incoming.mr = id_memread;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!mem_busy) begin
            older[2] = older[1];
            if (mem_br_taken) begin
                older[1] = empty_slot();
                older[0] = empty_slot();
            end else if (hz) begin
                older[1] = older[0];
                older[0] = empty_slot();
                if (model_cnt < CNT_SAT) model_cnt++;
            end else begin
                older[1] = older[0];
                older[0] = incoming;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int rn, input bit urn, input int rm, input bit urm,
                          input int rd, input bit rw, input bit mr);
        id_valid = v; id_rn = REG_AW'(rn); id_use_rn = urn; id_rm = REG_AW'(rm); id_use_rm = urm;
        id_rd = REG_AW'(rd); id_regwrite = rw; id_memread = mr;
    endtask

    task automatic ldur(input int rd);            set_id(1, 5, 1, 0, 0, rd, 1, 1); endtask
    task automatic add_reading(input int rn);     set_id(1, rn, 1, 4, 1, 6, 1, 0);  endtask

    // Asserted between clock edges; outputs must fall back to the idle state without waiting for clk.
    task automatic async_reset(input string tag);
        mem_busy = 0; mem_br_taken = 0;
        rst_n = 0;
        model_reset();
        #1;
        check({tag, ".pc_write"},    32'(pc_write),    32'd1);
        check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'd0);
        check({tag, ".stall_cnt"},   32'(stall_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic int pick_reg();
        case ($urandom_range(0, 4))
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 0;
            default: return ZERO_REG;
        endcase
    endfunction

    initial begin
        int cnt_before;
        model_reset();

        // Reset held with random ID fields.
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            set_id(1'($urandom), pick_reg(), 1'($urandom), pick_reg(), 1'($urandom), pick_reg(), 1'($urandom), 1'($urandom));
            tick("reset_hold");
        end
        rst_n = 1;

        // Load-use: exactly one stall cycle.
        ldur(2);         tick("ldu_load");
        add_reading(2);  tick("ldu_stall");
        tick("ldu_resume");
        check("ldu_cnt", 32'(stall_cnt), 32'd1);

        // XZR never hazards.
        ldur(ZERO_REG);        tick("xzr_load");
        add_reading(ZERO_REG); tick("xzr_add");

        // Taken branch overrides a pending load-use hazard.
        ldur(2);         tick("br_load");
        add_reading(2); mem_br_taken = 1; tick("br_flush");
        mem_br_taken = 0; tick("br_after");
        check("br_cnt", 32'(stall_cnt), 32'd1);

        // Freeze over a pending hazard, then the stall happens once.
        ldur(2);         tick("busy_load");
        add_reading(2);  mem_busy = 1;
        for (int i = 0; i < 3; i++) tick("busy_freeze");
        mem_busy = 0;    tick("busy_stall");
        tick("busy_resume");
        check("busy_cnt", 32'(stall_cnt), 32'd2);

        // Branch held through a freeze flushes only once busy drops.
        ldur(2);         tick("busybr_load");
        add_reading(2);  mem_busy = 1; mem_br_taken = 1;
        for (int i = 0; i < 3; i++) tick("busybr_freeze");
        mem_busy = 0;    tick("busybr_flush");
        mem_br_taken = 0; tick("busybr_after");

        // Reset arriving mid-stall.
        ldur(2);         tick("midrst_load");
        add_reading(2);
        #1 check("midrst_pre_bubble", 32'(idex_bubble), 32'd1);
        async_reset("midrst");
        tick("midrst_after");

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            ldur(2);        tick("sat_load");
            add_reading(2); tick("sat_stall");
            tick("sat_resume");
        end
        check("sat_cnt", 32'(stall_cnt), 32'(CNT_SAT));

        // ADD X3 -> SUB X3, and STUR-style non-writer of X3 followed by a reader.
        async_reset("nofwd_rst");
        set_id(1, 1, 1, 2, 1, 3, 1, 0);  tick("raw_add");
        set_id(1, 3, 1, 4, 1, 7, 1, 0);  tick("raw_sub0");
        tick("raw_sub1");
        tick("raw_sub2");
        tick("raw_sub3");
`ifdef PIPE_NO_FWD_EN
        check("raw_cnt", 32'(stall_cnt), 32'd2);
`else
        check("raw_cnt", 32'(stall_cnt), 32'd0);
`endif
        cnt_before = model_cnt;
        set_id(1, 1, 1, 3, 1, 3, 0, 0);  tick("stur");
        set_id(1, 3, 1, 3, 1, 8, 1, 0);  tick("stur_reader");
        tick("stur_reader2");
        check("stur_cnt", 32'(stall_cnt), 32'(cnt_before));

        // Random traffic with one reset in the middle.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) async_reset("rand_rst");
            set_id(($urandom_range(0, 7) != 0), pick_reg(), 1'($urandom), pick_reg(), 1'($urandom),
                   pick_reg(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            mem_busy     = ($urandom_range(0, 5) == 0);
            mem_br_taken = ($urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage ARMv8 core; sits beside the decode-stage control unit.
- Keeps a shadow scoreboard of the destination registers in flight in ID/EX, EX/MEM and MEM/WB.
- Produces PC/IF-ID write enables, the ID/EX bubble, and the flushes on a taken branch resolved in MEM.
- Counts hazard-stall cycles for performance analysis.

Parameters:
- REG_AW, 5, register address width.
- ZERO_REG, 31, XZR index; never a hazard source or target.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rn  in  REG_AW  first source register.
- id_rm  in  REG_AW  second source register (Reg2Loc-selected Rm/Rt).
- id_use_rn  in  1  instruction reads Rn.
- id_use_rm  in  1  instruction reads the second source.
- id_rd  in  REG_AW  destination register.
- id_regwrite  in  1  RegWrite from the CU.
- id_memread  in  1  MemRead from the CU.
- mem_br_taken  in  1  branch resolved taken in the MEM stage.
- mem_busy  in  1  data memory not ready; freeze the whole pipeline.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- idex_bubble  out  1  zero the control fields of ID/EX.
- flush_ifid, flush_idex, flush_exmem  out  1 each  clear those stage registers.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Shadow entries:
  - S1 tracks ID/EX, S2 tracks EX/MEM, S3 tracks MEM/WB.
  - Each entry holds {v, rd, rw, mr}.
  - Reset clears all of them, and stall_cnt = 0, asynchronously.
- Write-match: Sx matches source r when Sx.v & Sx.rw & Sx.rd == r & r != ZERO_REG.
  - A source counts only when its use_* is set and id_valid = 1.
- Load-use hazard: S1.mr & S1 write-matches either used source.
- The register file is write-through, so S3 never causes a hazard.
- Outputs are combinational from the shadow state and inputs.
- Priority 1, mem_busy = 1:
  - pc_write = 0, ifid_write = 0, idex_bubble = 0, all flushes = 0.
  - Shadow entries and counter hold.
  - mem_br_taken is ignored; MEM holds it until the cycle it is not busy.
- Priority 2, mem_br_taken = 1:
  - flush_ifid = flush_idex = flush_exmem = 1; pc_write = 1; ifid_write = 1; idex_bubble = 0.
  - Next: S3 <= S2 (the branch itself); S2.v <= 0; S1.v <= 0.
  - Any concurrent hazard is discarded and the counter does not increment.
- Priority 3, hazard:
  - pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - Next: S3 <= S2, S2 <= S1, S1.v <= 0.
  - stall_cnt increments, saturating at all-ones with no wrap.
- Otherwise:
  - pc_write = 1, ifid_write = 1, idex_bubble = 0, flushes = 0.
  - Next: S3 <= S2, S2 <= S1, S1 <= {id_valid, id_rd, id_regwrite, id_memread}.
- Reset values of outputs (state cleared, inputs low): pc_write = 1, ifid_write = 1, idex_bubble = 0, flushes = 0, stall_cnt = 0.
- Reset asserted mid-stall or mid-flush drops all in-flight hazard state immediately.
- A load-use stall lasts exactly 1 cycle: the load moves to S2, where it no longer triggers without the optional feature's extra rule.
- id_rd is ignored when id_regwrite = 0, so STUR/CBZ never create hazards.

Optional Feature:
- Macro: PIPE_NO_FWD_EN.
- When defined, the core has no forwarding unit. The hazard condition becomes any write-match of a used source in S1 or S2, whether or not the entry is a load.
  - ADD followed by a dependent SUB stalls 2 cycles.
  - With one independent instruction between them, it stalls 1 cycle.
- When undefined, only the load-use rule applies.
- Counter, flush and freeze behaviour are identical in both builds.

Test Plan:
- Reset, then hold rst_n = 0 with random inputs -> pc_write = 1, ifid_write = 1, idex_bubble = 0, stall_cnt = 0; no flush asserted.
- LDUR X2 (rd = 2, mr = 1) followed by ADD reading rn = 2 -> exactly 1 cycle of pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_cnt = 1. Repeat with rn = 31 -> no stall.
- LDUR X2 in S1 while mem_br_taken = 1 -> all three flushes = 1, no bubble, stall_cnt unchanged; next cycle S1.v = S2.v = 0, and an ADD reading X2 does not stall.
- mem_busy = 1 for 3 cycles during a pending load-use hazard -> outputs frozen with no bubble. The stall occurs once busy drops and stall_cnt rises by exactly 1. Repeat with mem_br_taken = 1 held throughout the busy window -> flushes assert only in the first non-busy cycle.
- CNT_W = 4, force 20 load-use stalls -> stall_cnt saturates at 15.
- PIPE_NO_FWD_EN defined, ADD X3 then SUB reading X3 -> 2 stall cycles, stall_cnt = 2. STUR (rw = 0, rd = 3) then a reader of X3 -> 0 stalls.
